// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-port bundle for the write-side arbiter
interface fifo_wr_arbiter_if #(
    parameter int Data_width = 8
);
    logic                    Wfull;
    logic                    Req0;
    logic [Data_width-1:0]   Data0;
    logic                    Req1;
    logic [2*Data_width-1:0] Data1;
    logic                    Gnt0;
    logic                    Gnt1;
    logic                    Winc;
    logic [Data_width-1:0]   Wrdata;
    logic                    Busy;

    modport slave (
        input  Wfull, Req0, Data0, Req1, Data1,
        output Gnt0, Gnt1, Winc, Wrdata, Busy
    );

    modport master (
        output Wfull, Req0, Data0, Req1, Data1,
        input  Gnt0, Gnt1, Winc, Wrdata, Busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter serialising a byte and a two-byte word into a FIFO
module fifo_wr_arbiter #(
    parameter int Data_width = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input logic              CLK,
    input logic              RST,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND_B0, SEND_W0, SEND_W1} state_e;

    state_e                  state_q, state_d;
    logic [2*Data_width-1:0] hold_q, hold_d;
    logic                    rr_q, rr_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic [Data_width-1:0]   last_q;
    logic [Data_width-1:0]   wrdata;
    logic [Data_width-1:0]   first_byte;
    logic [Data_width-1:0]   second_byte;
    logic                    sending;
    logic                    winc;
    logic                    pick0;
    logic                    pick1;

    assign first_byte  = LSB_FIRST ? hold_q[Data_width-1:0] : hold_q[2*Data_width-1:Data_width];
    assign second_byte = LSB_FIRST ? hold_q[2*Data_width-1:Data_width] : hold_q[Data_width-1:0];
    assign sending     = (state_q != IDLE);
    assign winc        = sending && !bus.Wfull;

    // rr_q low favours requester 0 when both are asking
    assign pick0 = bus.Req0 && (!bus.Req1 || !rr_q);
    assign pick1 = bus.Req1 && (!bus.Req0 || rr_q);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        wrdata  = last_q;
        case (state_q)
            IDLE: begin
                if (pick0) begin
                    state_d = SEND_B0;
                    hold_d  = {{Data_width{1'b0}}, bus.Data0};
                    gnt0_d  = 1'b1;
                    rr_d    = 1'b1;
                end else if (pick1) begin
                    state_d = SEND_W0;
                    hold_d  = bus.Data1;
                    gnt1_d  = 1'b1;
                    rr_d    = 1'b0;
                end
            end
            SEND_B0: begin
                wrdata = hold_q[Data_width-1:0];
                if (winc) state_d = IDLE;
            end
            SEND_W0: begin
                wrdata = first_byte;
                if (winc) state_d = SEND_W1;
            end
            SEND_W1: begin
                wrdata = second_byte;
                if (winc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q lets Wrdata keep showing the final written byte while idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            last_q  <= wrdata;
        end
    end

    assign bus.Gnt0   = gnt0_q;
    assign bus.Gnt1   = gnt1_q;
    assign bus.Winc   = winc;
    assign bus.Wrdata = wrdata;
    assign bus.Busy   = sending;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        wfull = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  data0 = '0;
    logic [15:0] data1 = '0;

    always #5 CLK = ~CLK;

    fifo_wr_arbiter_if #(.Data_width(8)) ia ();
    fifo_wr_arbiter_if #(.Data_width(8)) ib ();

    assign ia.Wfull = wfull;
    assign ia.Req0  = req0;
    assign ia.Data0 = data0;
    assign ia.Req1  = req1;
    assign ia.Data1 = data1;
    assign ib.Wfull = wfull;
    assign ib.Req0  = req0;
    assign ib.Data0 = data0;
    assign ib.Req1  = req1;
    assign ib.Data1 = data1;

    fifo_wr_arbiter #(.Data_width(8), .LSB_FIRST(1'b1)) dut_a (.CLK(CLK), .RST(RST), .bus(ia));
    fifo_wr_arbiter #(.Data_width(8), .LSB_FIRST(1'b0)) dut_b (.CLK(CLK), .RST(RST), .bus(ib));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        r0;
        logic [7:0]  d0;
        logic        r1;
        logic [15:0] d1;
        logic        wf;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r0, logic [7:0] d0, logic r1, logic [15:0] d1, logic wf,
                                logic g0, logic g1, logic wi, logic bz, logic [7:0] wd);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.wf = wf;
        v.exp = {g0, g1, wi, bz, wd};
        return v;
    endfunction

    // Reference: a queue of bytes still owed to the FIFO; empty queue means idle
    logic [7:0] mq[$];
    bit         m_rr;
    logic [7:0] m_last;
    bit         m_g0;
    bit         m_g1;

    function automatic logic [11:0] model_out();
        logic bz;
        bz = (mq.size() != 0);
        return {m_g0, m_g1, bz && !wfull, bz, bz ? mq[0] : m_last};
    endfunction

    task automatic model_step();
        int pick;
        if (!RST) begin
            mq.delete();
            m_rr = 0; m_last = '0; m_g0 = 0; m_g1 = 0;
        end else begin
            m_g0 = 0; m_g1 = 0;
            if (mq.size() != 0) begin
                if (!wfull) m_last = mq.pop_front();
            end else begin
                pick = -1;
                if (req0 && req1) pick = m_rr ? 1 : 0;
                else if (req0)    pick = 0;
                else if (req1)    pick = 1;
                if (pick == 0) begin
                    mq.push_back(data0); m_g0 = 1; m_rr = 1;
                end else if (pick == 1) begin
                    mq.push_back(data1[7:0]); mq.push_back(data1[15:8]); m_g1 = 1; m_rr = 0;
                end
            end
        end
    endtask

    function automatic logic [11:0] out_a();
        return {ia.Gnt0, ia.Gnt1, ia.Winc, ia.Busy, ia.Wrdata};
    endfunction

    function automatic logic [11:0] out_b();
        return {ib.Gnt0, ib.Gnt1, ib.Winc, ib.Busy, ib.Wrdata};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {g0,g1,winc,busy,wrdata}=%03h expected %03h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [7:0] d0, input logic r1, input logic [15:0] d1, input logic wf);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; wfull = wf;
    endtask

    initial begin
        // reset held with both requesters asking
        drive(1'b1, 8'h11, 1'b1, 16'hBEEF, 1'b0);
        model_step();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            check("reset_a", out_a(), 12'h000);
            check("reset_b", out_b(), 12'h000);
            model_step();
        end

        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 1, 0, 1, 1, 8'h11));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 0, 0, 8'h11));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 1, 1, 1, 8'hEF));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 1, 1, 8'hBE));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 0, 0, 8'hBE));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 1, 0, 1, 1, 8'h11));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 0, 0, 8'h11));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 1, 1, 1, 8'hEF));
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0, 0, 0, 1, 1, 8'hBE));
        tbl.push_back(mk(0, 8'h11, 0, 16'hBEEF, 0, 0, 0, 0, 0, 8'hBE));
        tbl.push_back(mk(1, 8'hA5, 0, 16'hBEEF, 0, 0, 0, 0, 0, 8'hBE));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 0, 1, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 0, 0, 0, 0, 0, 8'hA5));
        tbl.push_back(mk(0, 8'hA5, 1, 16'hBEEF, 0, 0, 0, 0, 0, 8'hA5));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 0, 0, 1, 1, 1, 8'hEF));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 1, 0, 0, 0, 1, 8'hBE));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 1, 0, 0, 0, 1, 8'hBE));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 1, 0, 0, 0, 1, 8'hBE));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 0, 0, 0, 1, 1, 8'hBE));
        tbl.push_back(mk(0, 8'hA5, 0, 16'hBEEF, 0, 0, 0, 0, 0, 8'hBE));
        tbl.push_back(mk(1, 8'h3C, 0, 16'hBEEF, 1, 0, 0, 0, 0, 8'hBE));
        tbl.push_back(mk(0, 8'h3C, 0, 16'hBEEF, 1, 1, 0, 0, 1, 8'h3C));
        tbl.push_back(mk(0, 8'h3C, 0, 16'hBEEF, 0, 0, 0, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 8'h3C, 0, 16'hBEEF, 0, 0, 0, 0, 0, 8'h3C));

        foreach (tbl[i]) begin
            @(negedge CLK);
            RST = 1'b1;
            drive(tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].wf);
            #1;
            check($sformatf("vec%0d", i), out_a(), tbl[i].exp);
            model_step();
        end

        // word order depends on LSB_FIRST: a writes 34,12 and b writes 12,34
        @(negedge CLK); drive(0, 8'h00, 1, 16'h1234, 0); #1; model_step();
        @(negedge CLK); drive(0, 8'h00, 0, 16'h1234, 0); #1;
        check("lsb1_w0", out_a(), {4'b0111, 8'h34});
        check("lsb0_w0", out_b(), {4'b0111, 8'h12});
        model_step();
        @(negedge CLK); #1;
        check("lsb1_w1", out_a(), {4'b0011, 8'h12});
        check("lsb0_w1", out_b(), {4'b0011, 8'h34});
        model_step();
        @(negedge CLK); #1;
        check("lsb1_idle", out_a(), {4'b0000, 8'h12});
        check("lsb0_idle", out_b(), {4'b0000, 8'h34});
        model_step();

        // reset asserted in the middle of the second byte of a word
        @(negedge CLK); drive(0, 8'h00, 1, 16'hCAFE, 0); #1; model_step();
        @(negedge CLK); drive(0, 8'h00, 0, 16'hCAFE, 0); #1;
        check("rst_w0", out_a(), {4'b0111, 8'hFE});
        model_step();
        @(negedge CLK); #1;
        check("rst_w1", out_a(), {4'b0011, 8'hCA});
        RST = 1'b0; #1;
        check("rst_async", out_a(), 12'h000);
        model_step();
        @(negedge CLK); #1; model_step();
        @(negedge CLK); RST = 1'b1; #1;
        check("rst_after", out_a(), 12'h000);
        model_step();
        @(negedge CLK); drive(1, 8'h5A, 0, 16'h0000, 0); #1;
        check("rst_idle", out_a(), 12'h000);
        model_step();
        @(negedge CLK); drive(0, 8'h5A, 0, 16'h0000, 0); #1;
        check("rst_new_gnt", out_a(), {4'b1011, 8'h5A});
        model_step();
        @(negedge CLK); #1;
        check("rst_new_done", out_a(), {4'b0000, 8'h5A});
        model_step();

        // random requesters that obey the hold-until-grant protocol
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (m_g0) begin
                req0 = 1'($urandom_range(0, 1)); data0 = 8'($urandom);
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; data0 = 8'($urandom);
            end
            if (m_g1) begin
                req1 = 1'($urandom_range(0, 1)); data1 = 16'($urandom);
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; data1 = 16'($urandom);
            end
            wfull = ($urandom_range(0, 9) < 3);
            #1;
            check($sformatf("rand%0d", c), out_a(), model_out());
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter and sequencer for the asynchronous FIFO, living entirely in the FIFO write clock domain.
- Shares the single FIFO write port between two requesters:
  - Requester 0 supplies one Data_width-bit byte (register-file read data).
  - Requester 1 supplies a 2*Data_width-bit word (ALU result), serialized into two FIFO writes.
- Round-robin arbitration with full-flag back-pressure; never overflows the FIFO.

Parameters:
- Data_width, 8, width of one FIFO entry and of Data0.
- LSB_FIRST, 1, 1 = requester-1 low byte written first; 0 = high byte first.

Ports:
- CLK  input  1  FIFO write clock (same clock as FIFO Wclk).
- RST  input  1  asynchronous, active-low reset.
- Wfull  input  1  FIFO full flag, write-clock domain.
- Req0  input  1  requester 0 request; held with Data0 until Gnt0.
- Data0  input  Data_width  requester 0 byte.
- Req1  input  1  requester 1 request; held with Data1 until Gnt1.
- Data1  input  2*Data_width  requester 1 word.
- Gnt0  output  1  one-cycle pulse: Data0 captured.
- Gnt1  output  1  one-cycle pulse: Data1 captured.
- Winc  output  1  FIFO write enable.
- Wrdata  output  Data_width  FIFO write data.
- Busy  output  1  high while a transfer is in progress (state != IDLE).

Behaviour:
- Reset: RST low asynchronously forces the following:
  - state=IDLE, Gnt0=Gnt1=0, Busy=0, Winc=0, Wrdata=0.
  - Holding registers cleared; round-robin pointer favours requester 0.
  - Reset mid-transfer discards the partially written word; no further Winc until a new grant.
- FSM states: IDLE, SEND_B0 (single byte), SEND_W0 (first byte of word), SEND_W1 (second byte of word).
- IDLE arbitration, evaluated on each rising edge:
  - Only Req0 high: capture Data0, Gnt0=1 next cycle, go to SEND_B0.
  - Only Req1 high: capture Data1, Gnt1=1 next cycle, go to SEND_W0.
  - Both high: grant the requester indicated by the round-robin pointer.
  - The pointer toggles to the other requester after every grant.
  - Neither high: stay in IDLE.
- Gnt0/Gnt1 are registered, high exactly one cycle (the first cycle of the SEND state), and mutually exclusive.
- Requesters drop or update Req after seeing Gnt. Req is ignored outside IDLE.
- Winc is combinational: Winc = (state is SEND_B0, SEND_W0 or SEND_W1) AND NOT Wfull.
- Wrdata is driven from the holding register:
  - SEND_B0: captured Data0.
  - SEND_W0: low byte if LSB_FIRST=1, else high byte.
  - SEND_W1: the remaining byte.
  - IDLE: Wrdata holds its last value; Winc=0.
- Transitions on a cycle with Winc=1:
  - SEND_B0 -> IDLE.
  - SEND_W0 -> SEND_W1.
  - SEND_W1 -> IDLE.
- While Wfull=1 the state and Wrdata hold; the write resumes the first cycle Wfull=0.
- Latency:
  - Req seen at edge N -> Gnt and first Winc possible in cycle N+1.
  - Single byte occupies 1 cycle; word occupies 2 consecutive cycles when not full.
  - One IDLE bubble cycle between transfers.
- Wfull high at grant time: grant still issues (data captured) and the write waits.
- Word bytes are always written contiguously in order; no other requester's byte is ever interleaved.

Test Plan:
- Reset: RST=0 with Req0=Req1=1 -> Gnt0=Gnt1=Winc=Busy=0, Wrdata=0. Release -> first grant goes to requester 0.
- Req0=1, Data0=0xA5, Wfull=0:
  - Gnt0 pulses 1 cycle.
  - Winc=1 for exactly that cycle with Wrdata=0xA5.
  - Back in IDLE next cycle.
- Req1=1, Data1=0x1234, LSB_FIRST=1 -> Gnt1 pulse, then Winc on two consecutive cycles with Wrdata=0x34 then 0x12. Repeat with LSB_FIRST=0 -> 0x12 then 0x34.
- Req0 and Req1 both held high continuously, Data0=0x11, Data1=0xBEEF:
  - Grant sequence is 0,1,0,1.
  - FIFO receives 0x11, 0xEF, 0xBE, 0x11, 0xEF, 0xBE.
- Req1 with Data1=0xBEEF; Wfull forced high for 3 cycles right after the 0xEF write:
  - Winc=0 for those 3 cycles with Wrdata held at 0xBE.
  - 0xBE is written on the first cycle Wfull=0; no extra or lost writes.
- RST pulsed low during SEND_W1 of a word -> Winc drops immediately, no further writes, Busy=0; a new Req0 afterwards is served normally.
